// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader.
package imem_loader_pkg;
  localparam int WORD_BYTES = 4;
  localparam int IMEM_DEPTH = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream, load control and instruction-memory write port of the loader.
interface imem_loader_if;
  logic        start;
  logic [9:0]  word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        cpu_hold;
  logic        done;
  logic        err;

  modport master (
    output start, word_count, byte_in, byte_valid,
    input  byte_ready, we, wa, wd, cpu_hold, done, err
  );

  modport slave (
    input  start, word_count, byte_in, byte_valid,
    output byte_ready, we, wa, wd, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word assembler: first byte shifted in ends up in word[31:24].
// full pulses combinationally on the shift that completes a word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  data_in,
  output logic [31:0] word,
  output logic        full
);
  localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

  logic [1:0]  cnt_q,  cnt_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear) begin
      cnt_d  = 2'd0;
      word_d = 32'd0;
    end else if (shift_en) begin
      cnt_d  = cnt_q + 2'd1;
      word_d = {word_q[23:0], data_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word = word_q;
  assign full = shift_en && !clear && (cnt_q == LAST_BYTE);
endmodule

// File: rtl/imem_loader.sv
// Streams a program from a byte host into instruction memory, holding the CPU meanwhile.
// All outputs decode from registered state, so reset forces them at once.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = IMEM_DEPTH
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.slave bus
);
  state_e      state_q, state_d;
  logic [9:0]  index_q, index_d;
  logic [9:0]  count_q, count_d;
  logic        err_q,   err_d;
  logic        pk_clear;
  logic        pk_shift;
  logic        pk_full;
  logic [31:0] pk_word;

  assign pk_shift = bus.byte_valid && (state_q == S_RECV);

  byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (pk_clear),
    .shift_en (pk_shift),
    .data_in  (bus.byte_in),
    .word     (pk_word),
    .full     (pk_full)
  );

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    count_d  = count_q;
    err_d    = err_q;
    pk_clear = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.word_count == 10'd0) begin
            state_d = S_DONE;
          end else if (int'(bus.word_count) > MAX_WORDS) begin
            err_d = 1'b1;
          end else begin
            count_d  = bus.word_count;
            index_d  = 10'd0;
            pk_clear = 1'b1;
            err_d    = 1'b0;
            state_d  = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (pk_full) state_d = S_WRITE;
      end
      S_WRITE: begin
        index_d = index_q + 10'd1;
        state_d = (index_q + 10'd1 == count_q) ? S_DONE : S_RECV;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      index_q <= 10'd0;
      count_q <= 10'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign bus.byte_ready = (state_q == S_RECV);
  assign bus.we         = (state_q == S_WRITE);
  assign bus.wa         = BASE_ADDR + {20'd0, index_q, 2'b00};
  assign bus.wd         = pk_word;
  assign bus.cpu_hold   = (state_q == S_RECV) || (state_q == S_WRITE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.err        = err_q;
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of the first instruction word written.
REQ-002 SHALL have parameter MAX_WORDS, default 64, meaning the largest legal word_count, equal to the instruction memory depth.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle load request, sampled only in IDLE.
REQ-006 SHALL have port word_count  input  10  number of 32-bit words to load, sampled with start.
REQ-007 SHALL have port byte_in  input  8  program byte from the host stream.
REQ-008 SHALL have port byte_valid  input  1  byte_in holds valid data.
REQ-009 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port we  output  1  write enable to the instruction memory write port.
REQ-011 SHALL have port wa  output  32  instruction memory byte address.
REQ-012 SHALL have port wd  output  32  instruction word being written.
REQ-013 SHALL have port cpu_hold  output  1  stalls the PC and the datapath while a load is in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a load completes.
REQ-015 SHALL have port err  output  1  sticky flag set when word_count is illegal.

Function
REQ-016 SHALL implement the states IDLE, RECV, WRITE and DONE.
REQ-017 IDLE: start=1 with 1<=word_count<=MAX_WORDS SHALL latch word_count, clear the word index and byte counter, clear err, and move to RECV.
REQ-018 IDLE: start=1 with word_count=0 SHALL move to DONE without writing anything.
REQ-019 IDLE: start=1 with word_count>MAX_WORDS SHALL set err and remain in IDLE.
REQ-020 A byte SHALL be accepted only on a rising edge where byte_valid=1 and byte_ready=1; byte_ready SHALL be 1 only in RECV.
REQ-021 Assembly SHALL be big-endian: the first accepted byte of a word goes to wd[31:24] and the fourth to wd[7:0].
REQ-022 Acceptance of the fourth byte SHALL move the block to WRITE; in the next cycle we=1 for exactly one cycle with stable wa and wd.
REQ-023 During WRITE, wa SHALL equal BASE_ADDR + 4*index, using 32-bit modulo-2^32 arithmetic.
REQ-024 After WRITE, index SHALL increment; if index+1 equals the latched count the block moves to DONE, otherwise it returns to RECV.
REQ-025 DONE SHALL assert done for one cycle and then move to IDLE.
REQ-026 cpu_hold SHALL be 1 in RECV and WRITE and 0 in IDLE and DONE.
REQ-027 start SHALL be ignored outside IDLE, and the latched word_count SHALL be unaffected by later changes on that input.
REQ-028 In RECV, gaps in byte_valid SHALL stall the block indefinitely with the partial word preserved; there SHALL be no timeout.
REQ-029 we SHALL be 0 in every state except WRITE.

Reset
REQ-030 Asserting reset SHALL immediately force IDLE, byte_ready=0, we=0, wa=BASE_ADDR, wd=0, cpu_hold=0, done=0 and err=0, and SHALL clear index and the byte counter.
REQ-031 Reset during RECV or WRITE SHALL abandon the load with no further writes; words already written are not rolled back.

Structure
REQ-032 The state encoding (2 bits) and the WORD_BYTES=4 constant SHALL live in the shared MIPS package, alongside the instruction memory depth constant.
REQ-033 A sub-module byte_packer SHALL hold the 2-bit byte counter and the 32-bit shift register, with inputs shift_en and clear and outputs word and full.

Verification
REQ-034 Scenario: word_count=2, bytes 20,08,00,05,AC,09,00,00 back-to-back -> writes (00000000, 20080005) then (00000004, AC090000); done pulses once; cpu_hold=0 afterwards.
REQ-035 Scenario: BASE_ADDR=0x400, word_count=1, byte_valid toggling every other cycle -> one write (00000400, bytes in order); byte_ready never drops inside RECV.
REQ-036 Scenario: word_count=0 -> done the cycle after IDLE; we never asserts; cpu_hold stays 0.
REQ-037 Scenario: word_count=65 with MAX_WORDS=64 -> err=1, state stays IDLE, no writes; a following legal start clears err.
REQ-038 Scenario: reset asserted after 2 bytes of word 1 of 3 -> all outputs at reset values asynchronously; a new start loads from BASE_ADDR again.
REQ-039 Scenario: start pulsed again mid-RECV with word_count=5 -> ignored; the original count of 2 completes.
